// File: rtl/keypad_pkg.sv
// Shared types and constants for the multi-tap keypad: scanner FSM states,
// special key codes and the ASCII letter-group helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } scanState_e;

    localparam logic [3:0] KEY_LAST_LETTER   = 4'd8;
    localparam logic [3:0] KEY_SUBMIT_LETTER = 4'd12;
    localparam logic [3:0] KEY_CLEAR         = 4'd13;
    localparam logic [3:0] KEY_SUBMIT_WORD   = 4'd14;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;

    function automatic logic [7:0] groupFirst(input logic [3:0] key);
        logic [7:0] k8;
        k8 = {4'b0000, key};
        return ASCII_A + k8 + k8 + k8;
    endfunction

    // The last group is short (Y, Z only), so its wrap point is fixed.
    function automatic logic [7:0] groupLast(input logic [3:0] key);
        return (key == KEY_LAST_LETTER) ? ASCII_Z : groupFirst(key) + 8'd2;
    endfunction

endpackage

// File: rtl/keypad_multitap_if.sv
// Keypad matrix lines plus the multi-tap text outputs seen by the game controller.
interface keypad_multitap_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] pending_letter;
    logic       pending_valid;
    logic [7:0] letter;
    logic       letter_valid;
    logic       clear_pulse;
    logic       word_submit;
    logic       error;

    modport master (
        output row,
        input  col, pending_letter, pending_valid, letter, letter_valid,
               clear_pulse, word_submit, error
    );

    modport slave (
        input  row,
        output col, pending_letter, pending_valid, letter, letter_valid,
               clear_pulse, word_submit, error
    );
endinterface

// File: rtl/keypad_scan.sv
// Column scanner with press/release debounce; emits one key_event per physical
// press together with the key code 4*row + column.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_event_o
);

    localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    scanState_e      state_q;
    logic [3:0]      col_q;
    logic [SC_W-1:0] scanCnt_q;
    logic [DB_W-1:0] dbCnt_q;
    logic [3:0]      rowLatch_q;
    logic [3:0]      keyCode_q;
    logic            keyEvent_q;
    logic [1:0]      rowIdx;
    logic [1:0]      colIdx;

    always_comb begin
        rowIdx = 2'd0;
        case (row_i)
            4'b0100: rowIdx = 2'd1;
            4'b0010: rowIdx = 2'd2;
            4'b0001: rowIdx = 2'd3;
            default: rowIdx = 2'd0;
        endcase
        colIdx = 2'd0;
        case (col_q)
            4'b0100: colIdx = 2'd1;
            4'b0010: colIdx = 2'd2;
            4'b0001: colIdx = 2'd3;
            default: colIdx = 2'd0;
        endcase
    end

    // Column stays locked from detection until the release has been debounced,
    // so a held key can never be seen as a second press.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_SCAN;
            col_q      <= 4'b1000;
            scanCnt_q  <= '0;
            dbCnt_q    <= '0;
            rowLatch_q <= '0;
            keyCode_q  <= '0;
            keyEvent_q <= 1'b0;
        end else begin
            keyEvent_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (scanCnt_q == SCAN_LAST) begin
                        scanCnt_q <= '0;
                        if ($onehot(row_i)) begin
                            state_q    <= ST_DEBOUNCE;
                            rowLatch_q <= row_i;
                            keyCode_q  <= {rowIdx, colIdx};
                            dbCnt_q    <= '0;
                        end else begin
                            col_q <= {col_q[0], col_q[3:1]};
                        end
                    end else begin
                        scanCnt_q <= scanCnt_q + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_i == rowLatch_q) begin
                        if (dbCnt_q == DB_LAST) begin
                            state_q    <= ST_PRESSED;
                            keyEvent_q <= 1'b1;
                            dbCnt_q    <= '0;
                        end else begin
                            dbCnt_q <= dbCnt_q + 1'b1;
                        end
                    end else begin
                        state_q   <= ST_SCAN;
                        col_q     <= {col_q[0], col_q[3:1]};
                        scanCnt_q <= '0;
                        dbCnt_q   <= '0;
                    end
                end
                ST_PRESSED: begin
                    state_q <= ST_RELEASE;
                    dbCnt_q <= '0;
                end
                ST_RELEASE: begin
                    if (row_i == 4'b0000) begin
                        if (dbCnt_q == DB_LAST) begin
                            state_q   <= ST_SCAN;
                            col_q     <= {col_q[0], col_q[3:1]};
                            scanCnt_q <= '0;
                            dbCnt_q   <= '0;
                        end else begin
                            dbCnt_q <= dbCnt_q + 1'b1;
                        end
                    end else begin
                        dbCnt_q <= '0;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    assign col_o       = col_q;
    assign key_code_o  = keyCode_q;
    assign key_event_o = keyEvent_q;

endmodule

// File: rtl/keypad_multitap.sv
// Multi-tap text entry: turns debounced key events into a pending letter,
// committed letters and one-cycle control pulses.
module keypad_multitap
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               nRst,
    keypad_multitap_if.slave   kp
);

    logic [3:0] keyCode;
    logic       keyEvent;

    logic [7:0] pendLetter_q;
    logic       pendValid_q;
    logic [3:0] pendGroup_q;
    logic [7:0] letter_q;
    logic       letterValid_q;
    logic       error_q;
    logic       clear_q;
    logic       wordSubmit_q;

    keypad_scan #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_scan (
        .clk         (clk),
        .nRst        (nRst),
        .row_i       (kp.row),
        .col_o       (kp.col),
        .key_code_o  (keyCode),
        .key_event_o (keyEvent)
    );

    // Repeated taps on the same group cycle through its letters; a different
    // group silently replaces the pending letter without committing it.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pendLetter_q  <= 8'h00;
            pendValid_q   <= 1'b0;
            pendGroup_q   <= 4'd0;
            letter_q      <= 8'h00;
            letterValid_q <= 1'b0;
            error_q       <= 1'b0;
            clear_q       <= 1'b0;
            wordSubmit_q  <= 1'b0;
        end else begin
            letterValid_q <= 1'b0;
            error_q       <= 1'b0;
            clear_q       <= 1'b0;
            wordSubmit_q  <= 1'b0;
            if (keyEvent) begin
                if (keyCode <= KEY_LAST_LETTER) begin
                    if (pendValid_q && (pendGroup_q == keyCode)) begin
                        pendLetter_q <= (pendLetter_q == groupLast(keyCode)) ?
                                        groupFirst(keyCode) : pendLetter_q + 8'd1;
                    end else begin
                        pendLetter_q <= groupFirst(keyCode);
                        pendGroup_q  <= keyCode;
                        pendValid_q  <= 1'b1;
                    end
                end else begin
                    case (keyCode)
                        KEY_SUBMIT_LETTER: begin
                            if (pendValid_q) begin
                                letter_q      <= pendLetter_q;
                                letterValid_q <= 1'b1;
                                pendLetter_q  <= 8'h00;
                                pendValid_q   <= 1'b0;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                        KEY_CLEAR: begin
                            clear_q      <= 1'b1;
                            pendLetter_q <= 8'h00;
                            pendValid_q  <= 1'b0;
                        end
                        KEY_SUBMIT_WORD: wordSubmit_q <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign kp.pending_letter = pendLetter_q;
    assign kp.pending_valid  = pendValid_q;
    assign kp.letter         = letter_q;
    assign kp.letter_valid   = letterValid_q;
    assign kp.error          = error_q;
    assign kp.clear_pulse    = clear_q;
    assign kp.word_submit    = wordSubmit_q;

endmodule

// File: tb/tb_keypad_multitap.sv
// Scoreboard bench for keypad_multitap: a matrix keypad model drives the rows,
// a letter-group reference model predicts every visible output change.
module tb_keypad_multitap;

    localparam int SCAN_CYCLES     = 4;
    localparam int DEBOUNCE_CYCLES = 8;

    typedef struct {
        logic [3:0] pulses;
        logic [7:0] letter;
        logic [7:0] pend;
        logic       pendValid;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [15:0] keysDown = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          modelPend = 0;
    exp_t        expQ[$];
    logic [7:0]  prevPend = 8'h00;
    logic        prevPendValid = 1'b0;
    logic [3:0]  monPulses;

    keypad_multitap_if kif();

    keypad_multitap #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .kp   (kif.slave)
    );

    always #5 clk = ~clk;

    // A closed key only shorts its row when its own column is being driven.
    always_comb begin
        kif.row = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keysDown[4*r+c] && kif.col[3-c]) kif.row[3-r] = 1'b1;
    end

    // Reference model: letters as arithmetic on 'A' + 3*group + position.
    task automatic modelKey(input int code);
        exp_t e;
        int first, size;
        e.pulses = 4'b0000;
        e.letter = 8'h00;
        if (code <= 8) begin
            first = 65 + 3 * code;
            size  = (code == 8) ? 2 : 3;
            if (modelPend != 0 && (modelPend - 65) / 3 == code)
                modelPend = first + ((modelPend - first + 1) % size);
            else
                modelPend = first;
        end else if (code == 12) begin
            if (modelPend != 0) begin
                e.pulses = 4'b1000;
                e.letter = 8'(modelPend);
                modelPend = 0;
            end else begin
                e.pulses = 4'b0100;
            end
        end else if (code == 13) begin
            e.pulses = 4'b0010;
            modelPend = 0;
        end else if (code == 14) begin
            e.pulses = 4'b0001;
        end else begin
            return;
        end
        e.pend      = 8'(modelPend);
        e.pendValid = (modelPend != 0);
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int code, input int hold);
        modelKey(code);
        keysDown[code] = 1'b1;
        idle(hold);
        keysDown = '0;
        idle(DEBOUNCE_CYCLES + 4 + $urandom_range(0, 6));
    endtask

    task automatic applyGlitch(input int code);
        keysDown[code] = 1'b1;
        idle($urandom_range(1, DEBOUNCE_CYCLES));
        keysDown = '0;
        idle(DEBOUNCE_CYCLES + 4 + $urandom_range(0, 6));
    endtask

    task automatic checkEq(input string name, input logic [7:0] act, input logic [7:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("[TB] FAIL %s got %h expected %h", name, act, want);
        end
    endtask

    task automatic checkResetState();
        checkEq("reset_col", {4'b0, kif.col}, 8'h08);
        checkEq("reset_pending_letter", kif.pending_letter, 8'h00);
        checkEq("reset_pending_valid", {7'b0, kif.pending_valid}, 8'h00);
        checkEq("reset_letter", kif.letter, 8'h00);
        checkEq("reset_pulses", {4'b0, kif.letter_valid, kif.error, kif.clear_pulse, kif.word_submit}, 8'h00);
    endtask

    task automatic checkOutput(input logic [3:0] p);
        exp_t e;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_event got pulses=%b pend=%h valid=%b expected no event",
                     p, kif.pending_letter, kif.pending_valid);
        end else begin
            e = expQ.pop_front();
            if (p !== e.pulses || kif.pending_letter !== e.pend || kif.pending_valid !== e.pendValid ||
                (e.pulses[3] && kif.letter !== e.letter)) begin
                miscompares++;
                $display("[TB] FAIL event got pulses=%b letter=%h pend=%h valid=%b expected pulses=%b letter=%h pend=%h valid=%b",
                         p, kif.letter, kif.pending_letter, kif.pending_valid,
                         e.pulses, e.letter, e.pend, e.pendValid);
            end
        end
    endtask

    // Monitor: any pulse or pending change is one observed DUT response.
    always @(negedge clk) begin
        if (!nRst) begin
            prevPend      = 8'h00;
            prevPendValid = 1'b0;
        end else begin
            monPulses = {kif.letter_valid, kif.error, kif.clear_pulse, kif.word_submit};
            if (monPulses != 4'b0000 || kif.pending_letter != prevPend || kif.pending_valid != prevPendValid)
                checkOutput(monPulses);
            prevPend      = kif.pending_letter;
            prevPendValid = kif.pending_valid;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        int code;
        idle(3);
        #1;
        checkResetState();
        @(negedge clk);
        nRst = 1'b1;
        idle(5);

        applyStimulus(0, 40);
        applyStimulus(0, 40);
        applyStimulus(0, 40);
        applyStimulus(12, 40);
        applyStimulus(8, 40);
        applyStimulus(8, 40);
        applyStimulus(8, 40);
        applyStimulus(13, 40);
        applyStimulus(12, 40);
        applyStimulus(3, 40);
        applyStimulus(13, 40);
        applyStimulus(10, 40);

        applyGlitch(5);
        keysDown = 16'h0011;
        idle(60);
        keysDown = '0;
        idle(DEBOUNCE_CYCLES + 6);
        applyStimulus(5, 1000);

        // Reset while key 14 is in debounce; it must be re-detected once.
        keysDown[14] = 1'b1;
        waited = 0;
        while (kif.col != 4'b0010 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (waited >= 200) begin
            miscompares++;
            $display("[TB] FAIL col_wait got col=%b expected 0010", kif.col);
        end
        idle(SCAN_CYCLES + 3);
        nRst = 1'b0;
        #1;
        modelPend = 0;
        checkResetState();
        @(negedge clk);
        nRst = 1'b1;
        modelKey(14);
        idle(40);
        keysDown = '0;
        idle(DEBOUNCE_CYCLES + 6);

        for (int i = 0; i < 40; i++) begin
            code = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) applyGlitch(code);
            else applyStimulus(code, $urandom_range(32, 80));
        end

        idle(50);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL missing_events got %0d outstanding expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
